// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - SimpleCPU opcode, condition and width definitions
package pc_sequencer_pkg;

    localparam int INS_W  = 16;
    localparam int ADDR_W = 8;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_LOAD    = 4'h1;
    localparam logic [3:0] OP_STORE   = 4'h2;
    localparam logic [3:0] OP_ADD     = 4'h3;
    localparam logic [3:0] OP_SUB     = 4'h4;
    localparam logic [3:0] OP_AND     = 4'h5;
    localparam logic [3:0] OP_OR      = 4'h6;
    localparam logic [3:0] OP_XOR     = 4'h7;
    localparam logic [3:0] OP_SHIFT   = 4'h8;
    localparam logic [3:0] OP_BR      = 4'h9;
    localparam logic [3:0] OP_BRC     = 4'hA;
    localparam logic [3:0] OP_BRSUB   = 4'hB;
    localparam logic [3:0] OP_RET     = 4'hC;
    localparam logic [3:0] OP_IN      = 4'hD;
    localparam logic [3:0] OP_OUT     = 4'hE;
    localparam logic [3:0] OP_LOADIMM = 4'hF;

    localparam logic [1:0] COND_Z = 2'b00;
    localparam logic [1:0] COND_N = 2'b01;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// rtl/pc_sequencer_return_stack.sv - hardware return-address stack for subroutine calls
module return_stack
    import pc_sequencer_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int RAS_PTR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    logic [RAS_PTR_W-1:0] sp_q, sp_d;
    logic [ADDR_W-1:0]    stack_q [RAS_DEPTH];
    logic [ADDR_W-1:0]    stack_d [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] rd_idx;

    assign full   = (sp_q == RAS_PTR_W'(RAS_DEPTH));
    assign empty  = (sp_q == '0);
    assign rd_idx = sp_q - RAS_PTR_W'(1);

    // Caller guarantees push only when not full and pop only when not empty.
    always_comb begin
        sp_d    = sp_q;
        stack_d = stack_q;
        dout    = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (rd_idx == RAS_PTR_W'(i)) dout = stack_q[i];
            if (push && sp_q == RAS_PTR_W'(i)) stack_d[i] = din;
        end
        if (push)     sp_d = sp_q + RAS_PTR_W'(1);
        else if (pop) sp_d = sp_q - RAS_PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) sp_q <= '0;
        else     sp_q <= sp_d;
        stack_q <= stack_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch program counter with branches, calls and returns
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter int         RAS_DEPTH = 4,
    parameter int         RAS_PTR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [INS_W-1:0]  ins,
    input  logic              z_flag,
    input  logic              n_flag,
    output logic [ADDR_W-1:0] pc,
    output logic              ras_ovf,
    output logic              ras_unf
);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, tgt, ras_dout;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              push, pop, ras_full, ras_empty;
    logic [3:0]        op;
    logic [1:0]        cond;
    logic              unused_ins;

    assign op         = ins[7:4];
    assign cond       = ins[3:2];
    assign tgt        = {ins[15:9], 1'b0};
    assign pc_inc     = pc_q + 8'd2;
    assign unused_ins = ^{ins[8], ins[1:0]};

    return_stack #(
        .RAS_DEPTH(RAS_DEPTH),
        .RAS_PTR_W(RAS_PTR_W)
    ) u_ras (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (pc_inc),
        .dout (ras_dout),
        .full (ras_full),
        .empty(ras_empty)
    );

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        pop   = 1'b0;
        if (!stall) begin
            pc_d = pc_inc;
            case (op)
                OP_BR: pc_d = tgt;
                OP_BRC: begin
                    if ((cond == COND_Z && z_flag) || (cond == COND_N && n_flag)) pc_d = tgt;
                end
                OP_BRSUB: begin
                    // A full stack still takes the call; only the return address is lost.
                    pc_d = tgt;
                    if (ras_full) ovf_d = 1'b1;
                    else          push  = 1'b1;
                end
                OP_RET: begin
                    if (ras_empty) begin
                        pc_d  = RESET_PC;
                        unf_d = 1'b1;
                    end else begin
                        pc_d = ras_dout;
                        pop  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc      = pc_q;
    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [15:0] ins = 16'h0000;
    logic        z_flag = 1'b0;
    logic        n_flag = 1'b0;
    logic [7:0]  pc;
    logic        ras_ovf, ras_unf;

    int tests = 0;
    int fails = 0;

    pc_sequencer #(
        .RESET_PC (8'h00),
        .RAS_DEPTH(4),
        .RAS_PTR_W(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .stall  (stall),
        .ins    (ins),
        .z_flag (z_flag),
        .n_flag (n_flag),
        .pc     (pc),
        .ras_ovf(ras_ovf),
        .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [15:0] i, input logic z, input logic n,
                        input logic s, input logic r);
        ins = i; z_flag = z; n_flag = n; stall = s; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++; if (pc !== 8'h00) begin fails++; $display("FAIL reset_pc got=%h exp=00", pc); end
        tests++; if (ras_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", ras_ovf); end
        tests++; if (ras_unf !== 1'b0) begin fails++; $display("FAIL reset_unf got=%b exp=0", ras_unf); end
    endtask

    task automatic test_sequential;
        logic [7:0] exp;
        for (int k = 1; k <= 15; k++) begin
            step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
            exp = 8'(2 * k);
            tests++; if (pc !== exp) begin fails++; $display("FAIL seq_step%0d got=%h exp=%h", k, pc, exp); end
        end
        tests++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
            fails++; $display("FAIL seq_flags got=%b%b exp=00", ras_ovf, ras_unf);
        end
    endtask

    task automatic test_cond_branch;
        step(16'h24A0, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h24) begin fails++; $display("FAIL brz_taken got=%h exp=24", pc); end
        step(16'h1E90, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h1E) begin fails++; $display("FAIL br_1e got=%h exp=1e", pc); end
        step(16'h24A0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h20) begin fails++; $display("FAIL brz_not_taken got=%h exp=20", pc); end
        step(16'h30A4, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++; if (pc !== 8'h30) begin fails++; $display("FAIL brn_taken got=%h exp=30", pc); end
        step(16'h24A0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++; if (pc !== 8'h32) begin fails++; $display("FAIL brz_ignores_n got=%h exp=32", pc); end
        step(16'h30A4, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h34) begin fails++; $display("FAIL brn_ignores_z got=%h exp=34", pc); end
        step(16'h24A8, 1'b1, 1'b1, 1'b0, 1'b0);
        tests++; if (pc !== 8'h36) begin fails++; $display("FAIL brc_cond10_nop got=%h exp=36", pc); end
        step(16'h24AC, 1'b1, 1'b1, 1'b0, 1'b0);
        tests++; if (pc !== 8'h38) begin fails++; $display("FAIL brc_cond11_nop got=%h exp=38", pc); end
        step(16'h2430, 1'b1, 1'b1, 1'b0, 1'b0);
        tests++; if (pc !== 8'h3A) begin fails++; $display("FAIL alu_op_nobranch got=%h exp=3a", pc); end
    endtask

    task automatic test_subroutine;
        step(16'h2890, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h28) begin fails++; $display("FAIL br_28 got=%h exp=28", pc); end
        step(16'h34B0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h34) begin fails++; $display("FAIL brsub_34 got=%h exp=34", pc); end
        step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h36) begin fails++; $display("FAIL sub_body got=%h exp=36", pc); end
        step(16'h00C0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h2A) begin fails++; $display("FAIL return_2a got=%h exp=2a", pc); end
    endtask

    task automatic test_overflow_underflow;
        logic [15:0] calls [5];
        logic [7:0]  call_pc [5];
        logic [7:0]  ret_pc [4];
        calls   = '{16'h40B0, 16'h50B0, 16'h60B0, 16'h70B0, 16'h80B0};
        call_pc = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        ret_pc  = '{8'h62, 8'h52, 8'h42, 8'h2C};
        for (int k = 0; k < 5; k++) begin
            step(calls[k], 1'b0, 1'b0, 1'b0, 1'b0);
            tests++; if (pc !== call_pc[k]) begin fails++; $display("FAIL call%0d_pc got=%h exp=%h", k, pc, call_pc[k]); end
            tests++; if (ras_ovf !== (k == 4)) begin fails++; $display("FAIL call%0d_ovf got=%b exp=%b", k, ras_ovf, k == 4); end
        end
        for (int k = 0; k < 4; k++) begin
            step(16'h00C0, 1'b0, 1'b0, 1'b0, 1'b0);
            tests++; if (pc !== ret_pc[k]) begin fails++; $display("FAIL ret%0d_pc got=%h exp=%h", k, pc, ret_pc[k]); end
            tests++; if (ras_unf !== 1'b0) begin fails++; $display("FAIL ret%0d_unf got=%b exp=0", k, ras_unf); end
        end
        tests++; if (ras_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", ras_ovf); end
        step(16'h00C0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h00) begin fails++; $display("FAIL underflow_pc got=%h exp=00", pc); end
        tests++; if (ras_unf !== 1'b1) begin fails++; $display("FAIL underflow_unf got=%b exp=1", ras_unf); end
        step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (ras_unf !== 1'b1 || ras_ovf !== 1'b1) begin
            fails++; $display("FAIL flags_sticky got=%b%b exp=11", ras_ovf, ras_unf);
        end
    endtask

    task automatic test_wrap_and_align;
        step(16'hFE90, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'hFE) begin fails++; $display("FAIL br_fe got=%h exp=fe", pc); end
        step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h00) begin fails++; $display("FAIL wrap_fe got=%h exp=00", pc); end
        step(16'h2590, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h24) begin fails++; $display("FAIL br_odd_tgt got=%h exp=24", pc); end
    endtask

    task automatic test_stall_and_reset;
        step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++; if (pc !== 8'h00 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
            fails++; $display("FAIL rst_clears got=%h/%b%b exp=00/00", pc, ras_ovf, ras_unf);
        end
        for (int k = 0; k < 3; k++) begin
            step(16'h34B0, 1'b0, 1'b0, 1'b1, 1'b0);
            tests++; if (pc !== 8'h00) begin fails++; $display("FAIL stall%0d_pc got=%h exp=00", k, pc); end
        end
        step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h02) begin fails++; $display("FAIL after_stall got=%h exp=02", pc); end
        step(16'h00C0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h00 || ras_unf !== 1'b1) begin
            fails++; $display("FAIL stall_no_push got=%h/%b exp=00/1", pc, ras_unf);
        end
        step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(16'h10B0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(16'h20B0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h20) begin fails++; $display("FAIL nested_call got=%h exp=20", pc); end
        step(16'h00C0, 1'b0, 1'b0, 1'b1, 1'b1);
        tests++; if (pc !== 8'h00 || ras_unf !== 1'b0) begin
            fails++; $display("FAIL rst_in_stall got=%h/%b exp=00/0", pc, ras_unf);
        end
        step(16'h00C0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (pc !== 8'h00 || ras_unf !== 1'b1) begin
            fails++; $display("FAIL rst_drops_stack got=%h/%b exp=00/1", pc, ras_unf);
        end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_cond_branch;
        test_subroutine;
        test_overflow_underflow;
        test_wrap_and_align;
        test_stall_and_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
